// File: rtl/bus_rr_xbar.sv
// bus_rr_xbar: shared-issue-slot crossbar from NrHosts hosts to NrDevices
// memory-mapped devices. Arbitration is round-robin. A FIFO of host ids per
// device routes each response back to the host that issued it. Addresses
// that match no device go to an internal error target. The error target
// answers one cycle after the grant with err=1.
module bus_rr_xbar #(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned NrDevices      = 3,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic [NrHosts-1:0]        host_req_i,
    output logic [NrHosts-1:0]        host_gnt_o,
    input  logic [AddressWidth-1:0]   host_addr_i  [NrHosts],
    input  logic [NrHosts-1:0]        host_we_i,
    input  logic [DataWidth/8-1:0]    host_be_i    [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]        host_rvalid_o,
    output logic [DataWidth-1:0]      host_rdata_o [NrHosts],
    output logic [NrHosts-1:0]        host_err_o,

    output logic [NrDevices-1:0]      device_req_o,
    output logic [AddressWidth-1:0]   device_addr_o  [NrDevices],
    output logic [NrDevices-1:0]      device_we_o,
    output logic [DataWidth/8-1:0]    device_be_o    [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
    input  logic [NrDevices-1:0]      device_rvalid_i,
    input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
    input  logic [NrDevices-1:0]      device_err_i,

    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

    localparam int unsigned HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned TgtW  = $clog2(NrDevices + 1);
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef logic [HostW-1:0] host_id_t;
    typedef logic [TgtW-1:0]  tgt_t;
    typedef logic [CntW-1:0]  cnt_t;
    typedef logic [PtrW-1:0]  ptr_t;

    // The error target uses the index just past the last real device.
    localparam tgt_t TgtErr = tgt_t'(NrDevices);
    localparam cnt_t CntMax = cnt_t'(MaxOutstanding);

    // Registered state and its next-state values.
    host_id_t rr_q, rr_d;
    cnt_t     out_cnt_q  [NrHosts];
    cnt_t     out_cnt_d  [NrHosts];
    tgt_t     last_tgt_q [NrHosts];
    tgt_t     last_tgt_d [NrHosts];
    host_id_t fifo_mem_q [NrDevices][MaxOutstanding];
    host_id_t fifo_mem_d [NrDevices][MaxOutstanding];
    ptr_t     fifo_wptr_q [NrDevices];
    ptr_t     fifo_wptr_d [NrDevices];
    ptr_t     fifo_rptr_q [NrDevices];
    ptr_t     fifo_rptr_d [NrDevices];
    cnt_t     fifo_cnt_q  [NrDevices];
    cnt_t     fifo_cnt_d  [NrDevices];
    logic     err_valid_q, err_valid_d;
    host_id_t err_host_q,  err_host_d;

    // Combinational signals.
    tgt_t             tgt [NrHosts];
    logic [NrHosts-1:0] eligible;
    logic             gnt_valid;
    host_id_t         gnt_host;
    tgt_t             gnt_tgt;
    logic [NrDevices-1:0] push;
    logic [NrDevices-1:0] pop;
    host_id_t         head [NrDevices];
    logic [NrHosts-1:0] resp_dup;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Decode each host address. The loop runs downward so that the lowest matching index wins.
    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            tgt[h] = TgtErr;
            for (int d = NrDevices - 1; d >= 0; d--) begin
                if ((host_addr_i[h] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                    tgt[h] = tgt_t'(d);
                end
            end
        end
    end

    // Eligibility: below the outstanding limit, same target as the requests still pending, and target FIFO has room.
    always_comb begin
        logic tgt_full;
        tgt_full = 1'b0;
        for (int h = 0; h < NrHosts; h++) begin
            tgt_full = 1'b0;
            for (int d = 0; d < NrDevices; d++) begin
                if ((tgt[h] == tgt_t'(d)) && (fifo_cnt_q[d] == CntMax)) tgt_full = 1'b1;
            end
            eligible[h] = rst_ni && host_req_i[h] && (out_cnt_q[h] < CntMax) &&
                          ((out_cnt_q[h] == '0) || (tgt[h] == last_tgt_q[h])) && !tgt_full;
        end
    end

    // Round-robin pick starting at the pointer, then drive the grant and device payload.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_host  = '0;
        for (int i = 0; i < NrHosts; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= int'(NrHosts)) idx = idx - int'(NrHosts);
            if (!gnt_valid && eligible[idx]) begin
                gnt_valid = 1'b1;
                gnt_host  = host_id_t'(idx);
            end
        end
        gnt_tgt    = gnt_valid ? tgt[gnt_host] : TgtErr;
        host_gnt_o = '0;
        if (gnt_valid) host_gnt_o[gnt_host] = 1'b1;
        rr_d = rr_q;
        if (gnt_valid) rr_d = (gnt_host == host_id_t'(NrHosts - 1)) ? '0 : gnt_host + 1'b1;
        device_we_o = '0;
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = gnt_valid && (gnt_tgt == tgt_t'(d));
            push[d]           = device_req_o[d];
            device_addr_o[d]  = '0;
            device_be_o[d]    = '0;
            device_wdata_o[d] = '0;
            if (gnt_valid) begin
                device_addr_o[d]  = host_addr_i[gnt_host];
                device_we_o[d]    = host_we_i[gnt_host];
                device_be_o[d]    = host_be_i[gnt_host];
                device_wdata_o[d] = host_wdata_i[gnt_host];
            end
        end
    end

    // Route device and error-target responses back to their hosts with no added latency.
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        resp_dup      = '0;
        for (int h = 0; h < NrHosts; h++) host_rdata_o[h] = '0;
        for (int d = 0; d < NrDevices; d++) begin
            pop[d]  = device_rvalid_i[d] && (fifo_cnt_q[d] != '0);
            head[d] = fifo_mem_q[d][fifo_rptr_q[d]];
            if (pop[d]) begin
                for (int h = 0; h < NrHosts; h++) begin
                    if (head[d] == host_id_t'(h)) begin
                        if (host_rvalid_o[h]) resp_dup[h] = 1'b1;
                        host_rvalid_o[h] = 1'b1;
                        host_rdata_o[h]  = device_rdata_i[d];
                        host_err_o[h]    = device_err_i[d];
                    end
                end
            end
        end
        if (err_valid_q) begin
            for (int h = 0; h < NrHosts; h++) begin
                if (err_host_q == host_id_t'(h)) begin
                    if (host_rvalid_o[h]) resp_dup[h] = 1'b1;
                    host_rvalid_o[h] = 1'b1;
                    host_rdata_o[h]  = '0;
                    host_err_o[h]    = 1'b1;
                end
            end
        end
    end

    // Update outstanding counters, last targets, the response FIFOs and the error-target slot.
    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            logic inc;
            inc           = gnt_valid && (gnt_host == host_id_t'(h));
            out_cnt_d[h]  = out_cnt_q[h];
            last_tgt_d[h] = last_tgt_q[h];
            if (inc && !host_rvalid_o[h]) out_cnt_d[h] = out_cnt_q[h] + 1'b1;
            if (!inc && host_rvalid_o[h]) out_cnt_d[h] = out_cnt_q[h] - 1'b1;
            if (inc) last_tgt_d[h] = gnt_tgt;
        end
        fifo_mem_d = fifo_mem_q;
        for (int d = 0; d < NrDevices; d++) begin
            fifo_wptr_d[d] = fifo_wptr_q[d];
            fifo_rptr_d[d] = fifo_rptr_q[d];
            fifo_cnt_d[d]  = fifo_cnt_q[d];
            if (push[d]) begin
                fifo_mem_d[d][fifo_wptr_q[d]] = gnt_host;
                fifo_wptr_d[d] = next_ptr(fifo_wptr_q[d]);
            end
            if (pop[d]) fifo_rptr_d[d] = next_ptr(fifo_rptr_q[d]);
            if (push[d] && !pop[d]) fifo_cnt_d[d] = fifo_cnt_q[d] + 1'b1;
            if (!push[d] && pop[d]) fifo_cnt_d[d] = fifo_cnt_q[d] - 1'b1;
        end
        err_valid_d = gnt_valid && (gnt_tgt == TgtErr);
        err_host_d  = err_valid_d ? gnt_host : '0;
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= '0;
            err_valid_q <= 1'b0;
            err_host_q  <= '0;
            for (int h = 0; h < NrHosts; h++) begin
                out_cnt_q[h]  <= '0;
                last_tgt_q[h] <= '0;
            end
            for (int d = 0; d < NrDevices; d++) begin
                fifo_wptr_q[d] <= '0;
                fifo_rptr_q[d] <= '0;
                fifo_cnt_q[d]  <= '0;
                for (int s = 0; s < MaxOutstanding; s++) fifo_mem_q[d][s] <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            err_valid_q <= err_valid_d;
            err_host_q  <= err_host_d;
            out_cnt_q   <= out_cnt_d;
            last_tgt_q  <= last_tgt_d;
            fifo_wptr_q <= fifo_wptr_d;
            fifo_rptr_q <= fifo_rptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_mem_q  <= fifo_mem_d;
        end
    end

    // Simulation checks for protocol violations that the logic cannot prevent.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            for (int d = 0; d < NrDevices; d++) begin
                assert (!(device_rvalid_i[d] && (fifo_cnt_q[d] == '0)))
                    else $warning("bus_rr_xbar: response from device %0d with no request pending, dropped", d);
                assert (!(push[d] && (fifo_cnt_q[d] == CntMax) && !pop[d]))
                    else $error("bus_rr_xbar: push into full response FIFO %0d", d);
            end
            assert (resp_dup == '0)
                else $error("bus_rr_xbar: two responses to one host in a single cycle");
        end
    end

endmodule
